// File: rtl/hybrid_control_pipe.sv
// Pipelined half-plane hybrid switching controller: z-transform, plane projection, hysteresis and dwell.
// Define HYBRID_CONTROL_DEBUG_EN to add the o_debug DAC output of the saturated jump value.
module hybrid_control_pipe #(
  parameter int     DATA_W    = 14,
  parameter int     COEF_W    = 32,
  parameter int     MU_Z1     = 110,
  parameter int     MU_Z2     = 121,
  parameter int     VG        = 240000,
  parameter longint HYST      = 0,
  parameter int     MIN_DWELL = 16
) (
  input  logic              i_clock,
  input  logic              i_RESET,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_vC,
  input  logic [DATA_W-1:0] i_iC,
  input  logic [COEF_W-1:0] i_cos,
  input  logic [COEF_W-1:0] i_sin,
  input  logic              i_coef_load,
  output logic              o_sigma,
  output logic              o_switch,
  output logic              o_valid,
  output logic              o_coef_busy
`ifdef HYBRID_CONTROL_DEBUG_EN
  ,
  output logic [13:0]       o_debug
`endif
);

  localparam int G_AB  = (MU_Z1 > MU_Z2) ? MU_Z1 : MU_Z2;
  localparam int G_MAX = (G_AB > VG) ? G_AB : VG;
  localparam int Z_W   = DATA_W + $clog2(G_MAX) + 2;
  localparam int P_W   = Z_W + COEF_W;
  localparam int J_W   = P_W + 1;
  localparam int CNT_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

  localparam logic signed [COEF_W-1:0] COEF_ONE = {2'b01, {(COEF_W-2){1'b0}}};
  localparam logic signed [Z_W-1:0]    K_Z1     = Z_W'(MU_Z1);
  localparam logic signed [Z_W-1:0]    K_Z2     = Z_W'(MU_Z2);
  localparam logic signed [Z_W-1:0]    K_VG     = Z_W'(VG);
  localparam logic signed [J_W-1:0]    HYST_P   = J_W'(HYST);
  localparam logic signed [J_W-1:0]    HYST_N   = -HYST_P;

  logic signed [DATA_W-1:0] w_vc, w_ic;
  logic signed [Z_W-1:0]    w_z1, w_z2;
  logic signed [P_W-1:0]    w_p1, w_p2;
  logic signed [J_W-1:0]    w_jump;
  logic                     w_toggle;

  logic signed [Z_W-1:0]    r_z1_p1, r_z2_p1;
  logic signed [P_W-1:0]    r_p1_p2, r_p2_p2;
  logic signed [J_W-1:0]    r_jump_p3;
  logic                     r_vld_p1, r_vld_p2, r_vld_p3;
  logic signed [COEF_W-1:0] r_cos_act, r_sin_act, r_cos_pend, r_sin_pend;
  logic [CNT_W-1:0]         r_dwell;
  logic                     r_sigma, r_switch, r_valid, r_busy;

  assign w_vc   = i_vC;
  assign w_ic   = i_iC;
  // z1 carries the input-voltage offset selected by the sigma in force this cycle
  assign w_z1   = K_Z1 * Z_W'(w_vc) + (r_sigma ? -K_VG : K_VG);
  assign w_z2   = K_Z2 * Z_W'(w_ic);
  assign w_p1   = P_W'(r_z1_p1) * P_W'(r_sin_act);
  assign w_p2   = P_W'(r_z2_p1) * P_W'(r_cos_act);
  assign w_jump = J_W'(r_p1_p2) + J_W'(r_p2_p2);

  always_comb begin
    w_toggle = 1'b0;
    if (r_vld_p3 && (r_dwell == '0)) begin
      if (r_jump_p3 > HYST_P)      w_toggle = r_sigma;
      else if (r_jump_p3 < HYST_N) w_toggle = ~r_sigma;
    end
  end

  // Stage p1: gain and offset; p2: plane projection; p3: jump sum
  always_ff @(posedge i_clock) begin
    if (i_valid) begin
      r_z1_p1 <= w_z1;
      r_z2_p1 <= w_z2;
    end
    r_p1_p2   <= w_p1;
    r_p2_p2   <= w_p2;
    r_jump_p3 <= w_jump;
  end

  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_vld_p3   <= 1'b0;
      r_sigma    <= 1'b1;
      r_switch   <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_dwell    <= '0;
      r_cos_act  <= COEF_ONE;
      r_sin_act  <= '0;
      r_cos_pend <= COEF_ONE;
      r_sin_pend <= '0;
    end else if (!i_enable) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_vld_p3  <= 1'b0;
      r_sigma   <= 1'b1;
      r_switch  <= 1'b0;
      r_valid   <= 1'b0;
      r_dwell   <= '0;
      r_cos_act <= r_cos_pend;
      r_sin_act <= r_sin_pend;
      r_busy    <= i_coef_load;
      if (i_coef_load) begin
        r_cos_pend <= i_cos;
        r_sin_pend <= i_sin;
      end
    end else begin
      r_vld_p1 <= i_valid;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
      r_valid  <= r_vld_p3;
      r_switch <= w_toggle;
      // A toggle is the only instant at which a new switching plane may be applied
      if (w_toggle) begin
        r_sigma   <= ~r_sigma;
        r_dwell   <= CNT_W'(MIN_DWELL);
        r_cos_act <= r_cos_pend;
        r_sin_act <= r_sin_pend;
      end else if (r_dwell != '0) begin
        r_dwell <= r_dwell - CNT_W'(1);
      end
      if (i_coef_load) begin
        r_cos_pend <= i_cos;
        r_sin_pend <= i_sin;
        r_busy     <= 1'b1;
      end else if (w_toggle) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_sigma     = r_sigma;
  assign o_switch    = r_switch;
  assign o_valid     = r_valid;
  assign o_coef_busy = r_busy;

`ifdef HYBRID_CONTROL_DEBUG_EN
  localparam int DBG_SH = P_W - 14;

  function automatic logic [13:0] dbg_code(input logic signed [J_W-1:0] j);
    logic signed [J_W-1:0] s;
    s = j >>> DBG_SH;
    if (s > J_W'(8191))       s = J_W'(8191);
    else if (s < -J_W'(8192)) s = -J_W'(8192);
    s = s + J_W'(8191);
    return s[13:0];
  endfunction

  logic [13:0] r_debug;

  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET)                    r_debug <= 14'd8191;
    else if (i_enable && r_vld_p3) r_debug <= dbg_code(r_jump_p3);
  end

  assign o_debug = r_debug;
`endif

endmodule

// File: tb/tb_hybrid_control_pipe.sv
// Bench for hybrid_control_pipe: directed steps then random traffic, two instances (default and hysteresis).
module tb_hybrid_control_pipe;

  localparam longint ONE    = 64'sd1073741824;
  localparam longint HYST_B = 64'sd20000 * 64'sd1073741824;

  logic        clk = 1'b0;
  logic        rst, en, vld, load;
  logic [13:0] vc, ic;
  logic [31:0] cosv, sinv;
  logic [1:0]  o_sig, o_sw, o_val, o_busy;
`ifdef HYBRID_CONTROL_DEBUG_EN
  logic [13:0] dbg0, dbg1;
`endif

  always #5 clk = ~clk;

  hybrid_control_pipe u_a (
    .i_clock(clk), .i_RESET(rst), .i_enable(en), .i_valid(vld),
    .i_vC(vc), .i_iC(ic), .i_cos(cosv), .i_sin(sinv), .i_coef_load(load),
    .o_sigma(o_sig[0]), .o_switch(o_sw[0]), .o_valid(o_val[0]), .o_coef_busy(o_busy[0])
`ifdef HYBRID_CONTROL_DEBUG_EN
    , .o_debug(dbg0)
`endif
  );

  hybrid_control_pipe #(.HYST(HYST_B), .MIN_DWELL(0)) u_h (
    .i_clock(clk), .i_RESET(rst), .i_enable(en), .i_valid(vld),
    .i_vC(vc), .i_iC(ic), .i_cos(cosv), .i_sin(sinv), .i_coef_load(load),
    .o_sigma(o_sig[1]), .o_switch(o_sw[1]), .o_valid(o_val[1]), .o_coef_busy(o_busy[1])
`ifdef HYBRID_CONTROL_DEBUG_EN
    , .o_debug(dbg1)
`endif
  );

  // Reference model: samples queue with the edge they were taken on
  typedef struct {
    longint z1;
    longint z2;
    longint jump;
    longint t;
  } ent_t;

  ent_t   q [2][$];
  bit     m_sig [2];
  bit     m_sw [2];
  bit     m_val [2];
  bit     m_busy [2];
  longint m_last [2];
  longint act_c [2];
  longint act_s [2];
  longint pend_c [2];
  longint pend_s [2];
  longint hyst [2];
  longint dwell [2];
  longint n;
  int     vectors;
  int     errors;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      m_sig[k]  = 1'b1;
      m_sw[k]   = 1'b0;
      m_val[k]  = 1'b0;
      m_busy[k] = 1'b0;
      m_last[k] = -1000;
      act_c[k]  = ONE;
      act_s[k]  = 0;
      pend_c[k] = ONE;
      pend_s[k] = 0;
    end
  endtask

  task automatic model_edge();
    longint pc, ps, ci, si, j;
    bit     tog;
    ent_t   e;
    n++;
    if (rst) begin
      model_reset();
      return;
    end
    ci = longint'($signed(cosv));
    si = longint'($signed(sinv));
    for (int k = 0; k < 2; k++) begin
      pc = pend_c[k];
      ps = pend_s[k];
      if (!en) begin
        q[k].delete();
        m_sig[k]  = 1'b1;
        m_sw[k]   = 1'b0;
        m_val[k]  = 1'b0;
        m_last[k] = -1000;
        act_c[k]  = pc;
        act_s[k]  = ps;
        m_busy[k] = load;
        if (load) begin
          pend_c[k] = ci;
          pend_s[k] = si;
        end
        continue;
      end
      tog      = 1'b0;
      m_val[k] = 1'b0;
      if (q[k].size() > 0 && q[k][0].t + 3 == n) begin
        m_val[k] = 1'b1;
        j = q[k][0].jump;
        if (n - m_last[k] > dwell[k]) begin
          if (j > hyst[k] && m_sig[k])        tog = 1'b1;
          else if (j < -hyst[k] && !m_sig[k]) tog = 1'b1;
        end
        void'(q[k].pop_front());
      end
      for (int i = 0; i < q[k].size(); i++)
        if (q[k][i].t + 1 == n)
          q[k][i].jump = q[k][i].z1 * act_s[k] + q[k][i].z2 * act_c[k];
      if (vld) begin
        e.z1   = 110 * longint'($signed(vc)) + (m_sig[k] ? -240000 : 240000);
        e.z2   = 121 * longint'($signed(ic));
        e.jump = 0;
        e.t    = n;
        q[k].push_back(e);
      end
      m_sw[k] = tog;
      if (tog) begin
        m_sig[k]  = !m_sig[k];
        m_last[k] = n;
        act_c[k]  = pc;
        act_s[k]  = ps;
        m_busy[k] = 1'b0;
      end
      if (load) begin
        pend_c[k] = ci;
        pend_s[k] = si;
        m_busy[k] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b edge=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sigma%0d", k), o_sig[k], m_sig[k]);
      chk($sformatf("switch%0d", k), o_sw[k], m_sw[k]);
      chk($sformatf("valid%0d", k), o_val[k], m_val[k]);
      chk($sformatf("busy%0d", k), o_busy[k], m_busy[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cyc(input int v, input int vcv, input int icv);
    vld = v[0];
    vc  = vcv[13:0];
    ic  = icv[13:0];
    step();
    vld = 1'b0;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) cyc(0, 0, 0);
  endtask

  task automatic load_coef(input int c, input int s);
    cosv = c;
    sinv = s;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int sweep_ic [7];
    bit sweep_b [7];
    int r;
    sweep_ic = '{100, 200, 100, -100, -200, -100, 300};
    sweep_b  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    hyst[0]  = 0;
    hyst[1]  = HYST_B;
    dwell[0] = 16;
    dwell[1] = 0;
    vectors  = 0;
    errors   = 0;
    n        = 0;
    rst = 1'b1; en = 1'b0; vld = 1'b0; load = 1'b0;
    vc = '0; ic = '0; cosv = '0; sinv = '0;
    model_reset();
    #1;
    check_all();
    chk("reset_sigma", o_sig[0], 1'b1);
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;

    // First decision: positive current pulls sigma to 0 three clocks later
    cyc(1, 0, 100);
    idle(3);
    chk("first_valid", o_val[0], 1'b1);
    chk("first_sigma", o_sig[0], 1'b0);
    chk("first_switch", o_sw[0], 1'b1);
    chk("first_hyst_hold", o_sig[1], 1'b1);

    // Dwell suppresses the opposite decision, a later one goes through
    idle(4);
    cyc(1, 0, -100);
    idle(3);
    chk("dwell_valid", o_val[0], 1'b1);
    chk("dwell_hold", o_sig[0], 1'b0);
    idle(20);
    cyc(1, 0, -100);
    idle(3);
    chk("post_dwell_sigma", o_sig[0], 1'b1);
    chk("post_dwell_switch", o_sw[0], 1'b1);

    // Hysteresis sweep on the banded instance
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, sweep_ic[i]);
      idle(3);
      chk($sformatf("hyst_sweep%0d", i), o_sig[1], sweep_b[i]);
      idle(1);
    end

    // Pending plane stays pending until the next toggle
    idle(20);
    cyc(1, 0, 200);
    idle(20);
    load_coef(0, 32'h4000_0000);
    chk("coef_busy_set", o_busy[0], 1'b1);
    idle(20);
    chk("coef_busy_held", o_busy[0], 1'b1);
    cyc(1, 0, -200);
    idle(3);
    chk("coef_toggle_sigma", o_sig[0], 1'b1);
    chk("coef_busy_clear", o_busy[0], 1'b0);
    idle(20);
    cyc(1, 4000, 0);
    idle(3);
    chk("z1_plane_sigma", o_sig[0], 1'b0);

    // Disable with samples in flight
    load_coef(32'h4000_0000, 0);
    cyc(1, 0, 100);
    cyc(1, 0, -100);
    en = 1'b0;
    step();
    chk("dis_sigma", o_sig[0], 1'b1);
    chk("dis_busy", o_busy[0], 1'b0);
    idle(3);
    chk("dis_no_valid", o_val[0], 1'b0);
    chk("dis_no_switch", o_sw[0], 1'b0);
    en = 1'b1;

    // Asynchronous reset in the middle of a dwell
    idle(2);
    cyc(1, 0, 200);
    idle(5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_sigma", o_sig[0], 1'b1);
    check_all();
    step();
    rst = 1'b0;
    cyc(1, 0, 200);
    idle(3);
    chk("after_rst_sigma", o_sig[0], 1'b0);
    chk("after_rst_switch", o_sw[0], 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 900; i++) begin
      if (!en) en = ($urandom_range(0, 2) == 0);
      else     en = ($urandom_range(0, 99) != 0);
      load = ($urandom_range(0, 39) == 0);
      if (load) begin
        r    = int'($urandom_range(0, 32'h7FFF_FFFF)) - 32'sh4000_0000;
        cosv = r;
        r    = int'($urandom_range(0, 32'h7FFF_FFFF)) - 32'sh4000_0000;
        sinv = r;
      end
      vld = $urandom_range(0, 1);
      vc  = 14'($urandom);
      ic  = 14'($urandom);
      step();
    end
    load = 1'b0;
    vld  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
